// File: rtl/sdram_sample_responder_if.sv
// sdram_sample_responder_if: Avalon-MM pipelined-read bus between a sample-store master and the responder.
interface sdram_sample_responder_if #(
    parameter int ADDR_W = 24
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic              waitrequest;
    logic [31:0]       readdata;
    logic              readdatavalid;
    modport master (output address, read, write, writedata, input waitrequest, readdata, readdatavalid);
    modport slave (input address, read, write, writedata, output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/sdram_sample_responder.sv
// sdram_sample_responder: Avalon-MM pipelined-read slave emulating the notch filter's SDRAM sample store.
// Define SDRAM_RESPONDER_STALL_INJECT_EN to force one waitrequest cycle every STALL_PERIOD cycles.
module sdram_sample_responder #(
    parameter int ADDR_W       = 24,
    parameter int DEPTH_W      = 10,
    parameter int WORD_SKIP    = 4,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PENDING  = 4,
    parameter int STALL_PERIOD = 7
) (
    input  logic                    clk,
    input  logic                    reset_n,
    sdram_sample_responder_if.slave bus,
    output logic [31:0]             reads_served,
    output logic [31:0]             writes_accepted,
    output logic                    range_err,
    output logic                    proto_err
);
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam logic [PW-1:0] PMAX = PW'(MAX_PENDING);
    logic [31:0]        mem [2**DEPTH_W];
    logic [31:0]        dly [READ_LATENCY];
    logic [ADDR_W-1:0]  word;
    logic [DEPTH_W-1:0] idx;
    logic               oor;
    logic               stall;
    logic               acc_rd;
    logic               acc_wr;
    logic [PW-1:0]      pending;
    logic [READ_LATENCY:0] vld;
    assign word = bus.address / ADDR_W'(WORD_SKIP);
    assign idx = word[DEPTH_W-1:0];
    assign oor = (word >> DEPTH_W) != '0;
    // A return this cycle frees its slot, so a full window still takes a read without a bubble.
    assign bus.waitrequest = !reset_n || (bus.read && bus.write) ||
                             (bus.read && pending == PMAX && !bus.readdatavalid) || stall;
    assign acc_rd = bus.read && !bus.waitrequest;
    assign acc_wr = bus.write && !bus.waitrequest;
    assign bus.readdatavalid = vld[READ_LATENCY];
`ifdef SDRAM_RESPONDER_STALL_INJECT_EN
    localparam int SW = $clog2(STALL_PERIOD + 1);
    logic [SW-1:0] stall_cnt;
    always_ff @(posedge clk) begin
        if (!reset_n) stall_cnt <= '0;
        else stall_cnt <= stall_cnt == SW'(STALL_PERIOD - 1) ? '0 : stall_cnt + 1'b1;
    end
    assign stall = stall_cnt == SW'(STALL_PERIOD - 1);
`else
    assign stall = 1'b0;
`endif
    // RAM is read on the accept edge, so earlier writes are seen and later writes are not.
    always_ff @(posedge clk) begin
        if (acc_wr) mem[idx] <= bus.writedata;
        dly[0] <= mem[idx];
        for (int i = 1; i < READ_LATENCY; i++) dly[i] <= dly[i-1];
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld             <= '0;
            pending         <= '0;
            bus.readdata    <= '0;
            reads_served    <= '0;
            writes_accepted <= '0;
            range_err       <= 1'b0;
            proto_err       <= 1'b0;
        end else begin
            vld             <= {vld[READ_LATENCY-1:0], acc_rd};
            pending         <= pending + PW'(acc_rd) - PW'(bus.readdatavalid);
            if (vld[READ_LATENCY-1]) bus.readdata <= dly[READ_LATENCY-1];
            reads_served    <= reads_served + 32'(bus.readdatavalid);
            writes_accepted <= writes_accepted + 32'(acc_wr);
            range_err       <= range_err || ((acc_rd || acc_wr) && oor);
            proto_err       <= proto_err || (bus.read && bus.write);
        end
    end
endmodule

// File: tb/tb_sdram_sample_responder.sv
// tb_sdram_sample_responder: random and directed traffic into two responder configurations, checked against a queue model.
module tb_sdram_sample_responder;
    typedef struct {
        int          due;
        logic [31:0] data;
    } ent_t;
    logic        clk;
    logic        reset_n;
    logic        read;
    logic        write;
    logic [23:0] address;
    logic [31:0] writedata;
    int          total = 0;
    int          bad = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic rd, input logic wr, input logic [23:0] a, input logic [31:0] wd);
        read = rd;
        write = wr;
        address = a;
        writedata = wd;
        step();
    endtask
    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int L = (g == 1) ? 6 : 2;
        localparam int MP = (g == 1) ? 2 : 4;
        sdram_sample_responder_if #(.ADDR_W(24)) bus ();
        logic [31:0] served;
        logic [31:0] wacc;
        logic        rerr;
        logic        perr;
        ent_t        q[$];
        logic [31:0] mem_m [1024];
        logic [31:0] last_rd;
        logic [31:0] srv_m;
        logic [31:0] wac_m;
        logic        rerr_m;
        logic        perr_m;
        logic        live;
        int          n;
        assign bus.address = address;
        assign bus.read = read;
        assign bus.write = write;
        assign bus.writedata = writedata;
        sdram_sample_responder #(.READ_LATENCY(L), .MAX_PENDING(MP)) dut (
            .clk(clk),
            .reset_n(reset_n),
            .bus(bus),
            .reads_served(served),
            .writes_accepted(wacc),
            .range_err(rerr),
            .proto_err(perr)
        );
        initial begin
            live = 1'b0;
            n = 0;
        end
        // Model state holds what the DUT should show after posedge n; it is then advanced past posedge n+1.
        always @(negedge clk) begin : model
            logic rv;
            logic wexp;
            logic ar;
            logic aw;
            int   idx;
            rv = q.size() > 0 && q[0].due == n;
            wexp = !reset_n || (read && write) || (read && q.size() >= MP && !rv);
            if (live) begin
                check($sformatf("waitrequest%0d", g), 32'(bus.waitrequest), 32'(wexp));
                check($sformatf("readdatavalid%0d", g), 32'(bus.readdatavalid), 32'(rv));
                if (rv) last_rd = q[0].data;
                check($sformatf("readdata%0d", g), bus.readdata, last_rd);
                check($sformatf("reads_served%0d", g), served, srv_m);
                check($sformatf("writes_accepted%0d", g), wacc, wac_m);
                check($sformatf("range_err%0d", g), 32'(rerr), 32'(rerr_m));
                check($sformatf("proto_err%0d", g), 32'(perr), 32'(perr_m));
            end
            if (!reset_n) begin
                q.delete();
                last_rd = 0;
                srv_m = 0;
                wac_m = 0;
                rerr_m = 1'b0;
                perr_m = 1'b0;
                live = 1'b1;
            end else begin
                if (rv) begin
                    q.delete(0);
                    srv_m++;
                end
                if (read && write) perr_m = 1'b1;
                ar = read && !wexp;
                aw = write && !wexp;
                idx = int'(address) / 4;
                if ((ar || aw) && idx >= 1024) rerr_m = 1'b1;
                if (aw) begin
                    mem_m[idx % 1024] = writedata;
                    wac_m++;
                end
                if (ar) q.push_back('{due: n + 1 + L, data: mem_m[idx % 1024]});
            end
            n++;
        end
    end
    initial begin
        int k;
        int r;
        reset_n = 1'b0;
        read = 1'b0;
        write = 1'b0;
        address = '0;
        writedata = '0;
        repeat (3) step();
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) drive(1'b0, 1'b1, 24'(4 * i), $urandom);
        drive(1'b0, 1'b1, 24'h000010, 32'h000000A5);
        drive(1'b1, 1'b0, 24'h000010, 32'h0);
        repeat (10) drive(1'b0, 1'b0, 24'h0, 32'h0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 24'(4 * i), 32'h0);
        repeat (12) drive(1'b0, 1'b0, 24'h0, 32'h0);
        check("b2b_reads_served", inst[0].served, 32'd10);
        k = 0;
        for (int i = 0; i < 60 && k < 5; i++) begin
            read = 1'b1;
            address = 24'(4 * k + 40);
            #1;
            if (!inst[1].bus.waitrequest) k++;
            step();
        end
        check("window_reads_taken", 32'(k), 32'd5);
        repeat (20) drive(1'b0, 1'b0, 24'h0, 32'h0);
        drive(1'b1, 1'b1, 24'h000010, 32'hDEADBEEF);
        repeat (3) drive(1'b0, 1'b0, 24'h0, 32'h0);
        check("proto_sticky0", 32'(inst[0].perr), 32'd1);
        check("proto_sticky1", 32'(inst[1].perr), 32'd1);
        drive(1'b1, 1'b0, 24'h000010, 32'h0);
        drive(1'b1, 1'b0, 24'h001000, 32'h0);
        repeat (12) drive(1'b0, 1'b0, 24'h0, 32'h0);
        check("range_sticky0", 32'(inst[0].rerr), 32'd1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 24'(4 * i), 32'h0);
        read = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (10) drive(1'b0, 1'b0, 24'h0, 32'h0);
        check("rst_reads_served", inst[0].served, 32'd0);
        check("rst_writes_accepted", inst[0].wacc, 32'd0);
        drive(1'b1, 1'b0, 24'h000010, 32'h0);
        repeat (10) drive(1'b0, 1'b0, 24'h0, 32'h0);
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            reset_n = $urandom_range(0, 299) != 0;
            drive(r < 45, r >= 40 && r < 75,
                  24'(($urandom_range(0, 9) == 0 ? 32'h1000 : 32'h0) + 4 * $urandom_range(0, 31) + $urandom_range(0, 3)),
                  $urandom);
        end
        reset_n = 1'b1;
        repeat (20) drive(1'b0, 1'b0, 24'h0, 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
